mdu_iter: RTL
=============

# mdu_iter

Iterative RV32M multiply/divide unit for the single-cycle CPU. It takes `rv1`/`rv2` from the register file read ports when the decoder issues an M-extension op, and stalls the core while it computes. It returns a tagged result that drives the register file write port (`rd`, `indata`, `we`) for one cycle.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock shared with the register file
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request; sampled only when the unit accepts (IDLE or DONE)
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- src1  in  32  rs1 value (from `rv1`)
- src2  in  32  rs2 value (from `rv2`)
- rd_in  in  5  destination register tag
- flush  in  1  synchronous abort; highest priority after reset
- busy  out  1  high in CALC and FIX; core stalls PC and other writes while high
- done  out  1  one-cycle pulse; result valid
- wb_data  out  32  result, held until the next accepted start
- wb_rd  out  5  tag of held result
- wb_we  out  1  `done && wb_rd != 0`

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept (IDLE or DONE, `start=1`, `flush=0`):
  - latch op, rd_in and operand magnitudes;
  - record result sign per op: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned; DIV/REM signed;
  - clear the 6-bit iteration count; go to CALC.
- Special cases bypass CALC and go directly to DONE with the result registered at the accept edge:
  - divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → src1;
  - signed overflow (src1=0x80000000, src2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- CALC runs one shift-add (multiply) or restoring shift-subtract (divide) step per edge, 32 steps.
  - Multiply keeps a 64-bit product; MUL takes the low word, MULH* take the high word.
  - Divide keeps a 32-bit quotient and a 33-bit partial remainder.
- After step 31 the unit goes to FIX, which applies two's-complement sign correction, registers `wb_data`, and goes to DONE.
  - Remainder sign follows the dividend.
  - Quotient sign is sign(src1) XOR sign(src2).
- DONE lasts one cycle with `done=1`. The unit then returns to IDLE, or to CALC/DONE if a new start is accepted in that cycle.
- `start` in CALC/FIX is ignored; no queuing.
- `flush=1`: next state IDLE, `done` suppressed, `wb_*` keep previous values. If `flush` and `start` are high together, `flush` wins.
- Reset (any time, including mid-CALC):
  - state IDLE;
  - busy=0, done=0, wb_we=0, wb_data=0, wb_rd=0;
  - count=0.

## Timing
- Start accepted at edge E:
  - busy=1 after E;
  - iterations at edges E+1..E+32;
  - FIX at edge E+33;
  - done=1 for the cycle after E+33;
  - idle, or next accept, at E+34.
- Special-case latency: done=1 in the cycle after E, and busy stays 0.
- Back-to-back: a start accepted in the DONE cycle gives exactly one `done` pulse per op and no gap cycle.
- `wb_data`, `wb_rd`, `busy` and `done` are registered outputs with no combinational path from inputs; `wb_we` is the only output decoded from registers.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 33×33 signed multiplier;
  - the result is registered at the accept edge and the unit goes to DONE (latency 1, busy never asserted);
  - divides are unchanged.
- Not defined: multiplies take the full 34-cycle iterative path described above.

## Structure
- Shared package `mdu_pkg` holds:
  - op encodings (MDU_MUL … MDU_REMU);
  - state encodings;
  - the constants XLEN=32 and ITER=32;
  - the special-case constants DIV0_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One sub-module, `mdu_iter_core`, contains the shared shift/add-subtract datapath for one iteration step (multiply or divide selected by a mode bit). The top level keeps the FSM, counter, sign logic and writeback registers.

## Test plan
- MUL 7×(−3), rd=5 → done 34 cycles after start; wb_data=0xFFFFFFEB, wb_we=1, wb_rd=5; busy high for exactly 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done 1 cycle after start. DIV 0x80000000/−1 → 0x80000000 and REM → 0. busy never asserts in either case.
- Writeback and issue corner cases:
  - rd_in=0 → done pulses, wb_we=0;
  - start while busy → ignored, one done only;
  - start in the DONE cycle → second done exactly 34 cycles later.
- Abort/reset, plus the configuration check:
  - flush at iteration 10 → no done, previous wb_data retained;
  - rst_n low at iteration 20 → all outputs 0 immediately;
  - with `MDU_FAST_MUL_EN` defined, MUL 7×(−3) → done 1 cycle after start.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - XLEN / ITER width and iteration constants
//   - DIV0_Q / INT_MIN special-case result constants
//   - mdu_op_e (funct3 encodings) and mdu_state_e (FSM states)
package mdu_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one combinational iteration step of the shared datapath.
//   div_mode = 0 : shift-add multiply step. {acc[31:0], lo} is the 64-bit
//                  product register, lo[0] is the current multiplier bit,
//                  opb is the multiplicand magnitude.
//   div_mode = 1 : restoring divide step. acc is the 33-bit partial
//                  remainder, lo shifts the dividend out of its MSB and the
//                  quotient bits into its LSB, opb is the divisor magnitude.
// Ports:
//   div_mode  in   step type select
//   acc       in   33-bit high accumulator / partial remainder
//   lo        in   32-bit low word (multiplier / dividend-quotient)
//   opb       in   32-bit multiplicand / divisor magnitude
//   acc_nx    out  next accumulator
//   lo_nx     out  next low word
module mdu_iter_core
  import mdu_pkg::*;
(
  input  logic            div_mode,
  input  logic [XLEN:0]   acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN:0]   acc_nx,
  output logic [XLEN-1:0] lo_nx
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;
  logic            ge;

  always_comb begin
    sum    = '0;
    diff   = '0;
    ge     = 1'b0;
    acc_nx = acc;
    lo_nx  = lo;
    if (div_mode) begin
      // Trial subtract of the divisor from the shifted remainder; the extra
      // top bit of diff is the borrow that decides restore vs. keep.
      diff   = {acc, lo[XLEN-1]} - {2'b00, opb};
      ge     = ~diff[XLEN+1];
      acc_nx = ge ? diff[XLEN:0] : {acc[XLEN-1:0], lo[XLEN-1]};
      lo_nx  = {lo[XLEN-2:0], ge};
    end else begin
      // Conditional add into the high word, then shift the whole 64-bit
      // product right by one with the carry entering at the top.
      sum    = {1'b0, acc[XLEN-1:0]} + (lo[0] ? {1'b0, opb} : '0);
      acc_nx = {1'b0, sum[XLEN:1]};
      lo_nx  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with tagged writeback.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle combinational
// multiplies; divides stay iterative).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          issue request, taken only in IDLE or DONE
//   op             funct3 (MUL..REMU)
//   src1, src2     rs1 / rs2 operand values
//   rd_in          destination register tag
//   flush          synchronous abort (wins over start)
//   busy           high in CALC and FIX
//   done           one-cycle result-valid pulse
//   wb_data/wb_rd  held result and its tag
//   wb_we          done && wb_rd != 0
// Handshake: start is a request with no ready; the core must stall while
// busy is high, and a result is consumed in the single cycle done is high.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we
);
  import mdu_pkg::*;

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_e, op_q;
  logic [5:0]      count_q;
  logic [XLEN:0]   acc_q, acc_nx;
  logic [XLEN-1:0] lo_q, lo_nx, opb_q;
  logic            neg_q, rneg_q;
  logic [4:0]      rd_q;
  logic            busy_q, done_q, busy_d, done_d;
  logic [XLEN-1:0] wb_data_q;
  logic [4:0]      wb_rd_q;

  // Accept-time decode
  logic            accept, is_div, a_signed, b_signed, sa, sb;
  logic            div0, ovf, fast_hit, short_path;
  logic [XLEN-1:0] mag_a, mag_b, short_res, fast_res, fix_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   q_s, r_s;

  assign op_e = mdu_op_e'(op);

  always_comb begin
    accept   = (state_q == ST_IDLE || state_q == ST_DONE) && start && !flush;
    is_div   = op[2];
    a_signed = (op_e == MDU_MUL) || (op_e == MDU_MULH) || (op_e == MDU_MULHSU) ||
               (op_e == MDU_DIV) || (op_e == MDU_REM);
    b_signed = (op_e == MDU_MUL) || (op_e == MDU_MULH) ||
               (op_e == MDU_DIV) || (op_e == MDU_REM);
    sa       = a_signed & src1[XLEN-1];
    sb       = b_signed & src2[XLEN-1];
    mag_a    = sa ? -src1 : src1;
    mag_b    = sb ? -src2 : src2;
    div0     = is_div && (src2 == '0);
    ovf      = ((op_e == MDU_DIV) || (op_e == MDU_REM)) &&
               (src1 == INT_MIN) && (src2 == DIV0_Q);
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic        [2*XLEN-1:0] fast_p;
  always_comb begin
    fast_a   = {sa, src1};
    fast_b   = {sb, src2};
    fast_p   = (2*XLEN)'(fast_a * fast_b);
    fast_hit = !is_div;
    fast_res = (op_e == MDU_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
  end
`endif

  always_comb begin
    short_path = div0 | ovf | fast_hit;
    // op[1] separates REM/REMU (6,7) from DIV/DIVU (4,5).
    if (div0)     short_res = op[1] ? src1 : DIV0_Q;
    else if (ovf) short_res = op[1] ? '0 : INT_MIN;
    else          short_res = fast_res;
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod   = {acc_q[XLEN-1:0], lo_q};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo_q : lo_q;
    r_s    = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    case (op_q)
      MDU_MUL:                      fix_res = prod_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:            fix_res = q_s;
      default:                      fix_res = r_s;
    endcase
  end

  mdu_iter_core u_core (
    .div_mode (op_q[2]),
    .acc      (acc_q),
    .lo       (lo_q),
    .opb      (opb_q),
    .acc_nx   (acc_nx),
    .lo_nx    (lo_nx)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE:
          if (start) state_d = short_path ? ST_DONE : ST_CALC;
          else       state_d = ST_IDLE;
        ST_CALC:
          if (count_q == 6'(ITER - 1)) state_d = ST_FIX;
        ST_FIX:
          state_d = ST_DONE;
        default:
          state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs, registered so busy/done have no path from inputs
  always_comb begin
    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // Datapath and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MDU_MUL;
      rd_q      <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else if (accept) begin
      op_q    <= op_e;
      rd_q    <= rd_in;
      count_q <= '0;
      acc_q   <= '0;
      lo_q    <= mag_a;
      opb_q   <= mag_b;
      neg_q   <= sa ^ sb;
      rneg_q  <= sa;
      if (short_path) begin
        wb_data_q <= short_res;
        wb_rd_q   <= rd_in;
      end
    end else if (!flush && state_q == ST_CALC) begin
      acc_q   <= acc_nx;
      lo_q    <= lo_nx;
      count_q <= count_q + 6'd1;
    end else if (!flush && state_q == ST_FIX) begin
      wb_data_q <= fix_res;
      wb_rd_q   <= rd_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_data = wb_data_q;
  assign wb_rd   = wb_rd_q;
  assign wb_we   = done_q && (wb_rd_q != 5'd0);

endmodule
